// File: rtl/db_unit_clk_switch_ctl.sv
// Sequences db_unit_clk divider changes: gate output, drain, load divider, wait for lock, settle, ungate.
// clk_out_en tracks the control register one cycle late in IDLE; select changes seen while busy wait for IDLE.
module db_unit_clk_switch_ctl #(
   parameter int DRAIN_CYC    = 4,
   parameter int SETTLE_CYC   = 8,
   parameter int LOCK_TIMEOUT = 256
) (
   input  logic        CRCU_CLK,
   input  logic        CRCU_RST_N,
   input  logic [31:0] db_unit_clock_ctl_reg,
   input  logic        div_locked,
   output logic [2:0]  div_sel,
   output logic        div_load,
   output logic        clk_out_en,
   output logic        busy,
   output logic        sw_done,
   output logic        sel_err,
   output logic        lock_err
);

   localparam int MAX_A = (DRAIN_CYC > SETTLE_CYC) ? DRAIN_CYC : SETTLE_CYC;
   localparam int MAX_P = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
   localparam int CW    = $clog2(MAX_P) + 1;

   localparam logic [CW-1:0] DRAIN_LAST   = CW'(DRAIN_CYC - 1);
   localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_MAX      = '1;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_DRAIN     = 3'd1,
      S_LOAD      = 3'd2,
      S_WAIT_LOCK = 3'd3,
      S_SETTLE    = 3'd4
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [2:0]    tgt;
   logic [2:0]    active_sel;
   logic [2:0]    failed_sel;
   logic          failed_vld;
   logic          revert;

   logic [2:0]    reg_sel;
   logic          reg_en;
   logic          reg_gate;
   logic          unused_reg_bits;
   logic          sel_invalid;
   logic          sel_pending;
   logic          launch;
   logic          lock_ok;
   logic          lock_to;
   logic          settle_end;
   logic          sw_done_nxt;
   logic          sel_err_nxt;
   logic          clk_out_en_nxt;

   assign reg_sel         = db_unit_clock_ctl_reg[2:0];
   assign reg_en          = db_unit_clock_ctl_reg[3];
   assign reg_gate        = db_unit_clock_ctl_reg[4];
   assign unused_reg_bits = ^db_unit_clock_ctl_reg[31:5];

   // A select that already failed is not retried until software moves off it.
   assign sel_invalid = (reg_sel > 3'd4);
   assign sel_pending = !sel_invalid && (reg_sel != active_sel) &&
                        !(failed_vld && (reg_sel == failed_sel));
   assign launch      = (state == S_IDLE) && sel_pending;

   // The divider may still report the old lock in the first cycle after div_load.
   assign lock_ok    = (state == S_WAIT_LOCK) && (cnt != '0) && div_locked;
   assign lock_to    = (state == S_WAIT_LOCK) && !lock_ok && (cnt >= TIMEOUT_LAST);
   assign settle_end = (state == S_SETTLE) && (cnt >= SETTLE_LAST);

   always_ff @(posedge CRCU_CLK or negedge CRCU_RST_N) begin
      if (!CRCU_RST_N) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:      if (sel_pending) state_nxt = S_DRAIN;
         S_DRAIN:     if (cnt >= DRAIN_LAST) state_nxt = S_LOAD;
         S_LOAD:      state_nxt = S_WAIT_LOCK;
         S_WAIT_LOCK: begin
            if (lock_ok)      state_nxt = S_SETTLE;
            else if (lock_to) state_nxt = revert ? S_SETTLE : S_LOAD;
         end
         S_SETTLE:    if (settle_end) state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      div_load       = (state == S_LOAD);
      busy           = (state != S_IDLE);
      sw_done_nxt    = settle_end && !revert;
      sel_err_nxt    = (state == S_IDLE) && sel_invalid;
      // Only ungate from an IDLE cycle that is not about to launch another switch.
      clk_out_en_nxt = reg_en && !reg_gate && (state == S_IDLE) && (state_nxt == S_IDLE);
   end

   always_ff @(posedge CRCU_CLK or negedge CRCU_RST_N) begin
      if (!CRCU_RST_N) begin
         cnt        <= '0;
         tgt        <= 3'd0;
         active_sel <= 3'd0;
         failed_sel <= 3'd0;
         failed_vld <= 1'b0;
         revert     <= 1'b0;
         div_sel    <= 3'd0;
         lock_err   <= 1'b0;
         sw_done    <= 1'b0;
         sel_err    <= 1'b0;
         clk_out_en <= 1'b0;
      end else begin
         if ((state_nxt != state) || (state == S_IDLE)) begin
            cnt <= '0;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
         end

         if (launch) begin
            tgt <= reg_sel;
         end else if (lock_to && !revert) begin
            tgt <= active_sel;
         end

         // div_sel is valid during the whole LOAD cycle so the divider samples it with div_load.
         if (state_nxt == S_LOAD) begin
            div_sel <= (state == S_WAIT_LOCK) ? active_sel : tgt;
         end

         if (lock_to) begin
            lock_err <= 1'b1;
         end else if (settle_end && !revert) begin
            lock_err <= 1'b0;
         end

         if (lock_to && !revert) begin
            revert <= 1'b1;
         end else if (settle_end) begin
            revert <= 1'b0;
         end

         if (settle_end && !revert) begin
            active_sel <= tgt;
         end

         if (lock_to && !revert) begin
            failed_vld <= 1'b1;
            failed_sel <= tgt;
         end else if (settle_end && !revert) begin
            failed_vld <= 1'b0;
         end else if (failed_vld && (reg_sel != failed_sel)) begin
            failed_vld <= 1'b0;
         end

         sw_done    <= sw_done_nxt;
         sel_err    <= sel_err_nxt;
         clk_out_en <= clk_out_en_nxt;
      end
   end

endmodule

// File: tb/tb_db_unit_clk_switch_ctl.sv
// Bench for db_unit_clk_switch_ctl: transaction-level model of switch outcomes and durations,
// with a divider model that drops lock on each div_load and relocks after a planned delay.
module tb_db_unit_clk_switch_ctl;

   localparam int DRAIN  = 4;
   localparam int SETTLE = 8;
   localparam int LT     = 256;
   localparam int NEVER  = 1000000;

   logic        clk;
   logic        rst_n;
   logic [31:0] ctl_reg;
   logic        div_locked;
   logic [2:0]  div_sel;
   logic        div_load;
   logic        clk_out_en;
   logic        busy;
   logic        sw_done;
   logic        sel_err;
   logic        lock_err;

   int checks   = 0;
   int failures = 0;
   int lock_plan[$];

   logic [2:0] m_active;
   logic [2:0] m_failed;
   logic [2:0] m_divsel;
   bit         m_failed_vld;
   bit         m_lock_err;

   db_unit_clk_switch_ctl #(
      .DRAIN_CYC   (DRAIN),
      .SETTLE_CYC  (SETTLE),
      .LOCK_TIMEOUT(LT)
   ) dut (
      .CRCU_CLK             (clk),
      .CRCU_RST_N           (rst_n),
      .db_unit_clock_ctl_reg(ctl_reg),
      .div_locked           (div_locked),
      .div_sel              (div_sel),
      .div_load             (div_load),
      .clk_out_en           (clk_out_en),
      .busy                 (busy),
      .sw_done              (sw_done),
      .sel_err              (sel_err),
      .lock_err             (lock_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Divider: loses lock when it sees div_load, regains it after the next planned delay.
   initial begin
      int rem;
      rem = 0;
      div_locked = 1'b1;
      forever begin
         @(negedge clk);
         if (div_load === 1'b1) begin
            rem = (lock_plan.size() > 0) ? lock_plan.pop_front() : 3;
            div_locked = 1'b0;
         end else if (rem > 0) begin
            rem--;
            if (rem == 0) div_locked = 1'b1;
         end
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int lock_wait(input int d);
      return (d < 2) ? 2 : d;
   endfunction

   task automatic model_reset();
      m_active     = 3'd0;
      m_failed     = 3'd0;
      m_divsel     = 3'd0;
      m_failed_vld = 1'b0;
      m_lock_err   = 1'b0;
   endtask

   // Writes select s (enabled, ungated) in IDLE and checks the whole resulting sequence.
   task automatic run_txn(input logic [2:0] s, input int d1, input int d2);
      bit         launch;
      bit         timed_out;
      bit         had_le;
      logic       prev_le;
      logic [2:0] exp_l1;
      logic [2:0] load_sel [2];
      int exp_busy, exp_loads, exp_sw, exp_se, exp_en_low, w;
      int busy_cnt, n_loads, load0_idx, sw_cnt, sw_idx, se_cnt, en_low, le_idx;

      launch    = (s <= 3'd4) && (s != m_active) && !(m_failed_vld && (s == m_failed));
      if (m_failed_vld && (s != m_failed)) m_failed_vld = 1'b0;
      exp_l1    = m_active;
      timed_out = 1'b0;
      exp_busy  = 0;
      exp_loads = 0;
      exp_sw    = 0;
      if (launch) begin
         if (d1 <= LT) begin
            exp_busy     = DRAIN + 1 + lock_wait(d1) + SETTLE;
            exp_loads    = 1;
            exp_sw       = 1;
            m_active     = s;
            m_divsel     = s;
            m_lock_err   = 1'b0;
            m_failed_vld = 1'b0;
         end else begin
            timed_out    = 1'b1;
            exp_loads    = 2;
            exp_busy     = DRAIN + 1 + LT + 1 + ((d2 <= LT) ? lock_wait(d2) : LT) + SETTLE;
            m_divsel     = m_active;
            m_lock_err   = 1'b1;
            m_failed_vld = 1'b1;
            m_failed     = s;
         end
      end
      w          = exp_busy + 6;
      exp_se     = (s > 3'd4) ? w : 0;
      exp_en_low = launch ? exp_busy + 1 : 0;

      had_le = lock_err;
      prev_le = lock_err;
      busy_cnt = 0; n_loads = 0; load0_idx = 0; sw_cnt = 0; sw_idx = 0;
      se_cnt = 0; en_low = 0; le_idx = 0;
      load_sel[0] = 3'd0;
      load_sel[1] = 3'd0;
      lock_plan.delete();
      lock_plan.push_back(d1);
      lock_plan.push_back(d2);
      ctl_reg = {27'd0, 1'b0, 1'b1, s};

      for (int i = 1; i <= w; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (!clk_out_en) en_low++;
         if (div_load) begin
            if (n_loads < 2) load_sel[n_loads] = div_sel;
            if (n_loads == 0) load0_idx = i;
            n_loads++;
         end
         if (sw_done) begin sw_cnt++; sw_idx = i; end
         if (sel_err) se_cnt++;
         if (lock_err && !prev_le && (le_idx == 0)) le_idx = i;
         prev_le = lock_err;
      end

      checks++; if (busy_cnt !== exp_busy) begin failures++;
         $display("FAIL busy_cycles sel=%0d: got %0d expected %0d", s, busy_cnt, exp_busy); end
      checks++; if (n_loads !== exp_loads) begin failures++;
         $display("FAIL div_load_count sel=%0d: got %0d expected %0d", s, n_loads, exp_loads); end
      if (exp_loads >= 1) begin
         checks++; if (load_sel[0] !== s) begin failures++;
            $display("FAIL load_sel sel=%0d: got %0d expected %0d", s, load_sel[0], s); end
         checks++; if (load0_idx !== DRAIN + 1) begin failures++;
            $display("FAIL load_time sel=%0d: got %0d expected %0d", s, load0_idx, DRAIN + 1); end
      end
      if (exp_loads == 2) begin
         checks++; if (load_sel[1] !== exp_l1) begin failures++;
            $display("FAIL revert_sel sel=%0d: got %0d expected %0d", s, load_sel[1], exp_l1); end
      end
      checks++; if (sw_cnt !== exp_sw) begin failures++;
         $display("FAIL sw_done_count sel=%0d: got %0d expected %0d", s, sw_cnt, exp_sw); end
      if (exp_sw == 1) begin
         checks++; if (sw_idx !== exp_busy + 1) begin failures++;
            $display("FAIL sw_done_time sel=%0d: got %0d expected %0d", s, sw_idx, exp_busy + 1); end
      end
      if (timed_out && !had_le) begin
         checks++; if (le_idx !== DRAIN + 2 + LT) begin failures++;
            $display("FAIL lock_err_time sel=%0d: got %0d expected %0d", s, le_idx, DRAIN + 2 + LT); end
      end
      checks++; if (se_cnt !== exp_se) begin failures++;
         $display("FAIL sel_err_count sel=%0d: got %0d expected %0d", s, se_cnt, exp_se); end
      checks++; if (en_low !== exp_en_low) begin failures++;
         $display("FAIL clk_out_en_low_cycles sel=%0d: got %0d expected %0d", s, en_low, exp_en_low); end
      checks++; if ({clk_out_en, busy} !== 2'b10) begin failures++;
         $display("FAIL final_en_busy sel=%0d: got %b expected 10", s, {clk_out_en, busy}); end
      checks++; if (div_sel !== m_divsel) begin failures++;
         $display("FAIL final_div_sel sel=%0d: got %0d expected %0d", s, div_sel, m_divsel); end
      checks++; if (lock_err !== m_lock_err) begin failures++;
         $display("FAIL final_lock_err sel=%0d: got %0d expected %0d", s, lock_err, m_lock_err); end
   endtask

   task automatic test_reset();
      int en_seen, loads, busy_seen;
      rst_n   = 1'b0;
      ctl_reg = 32'h08;
      model_reset();
      repeat (3) @(negedge clk);
      checks++; if ({div_sel, div_load, clk_out_en, busy, sw_done, sel_err, lock_err} !== 9'd0) begin
         failures++;
         $display("FAIL reset_outputs: got %b expected 0",
                  {div_sel, div_load, clk_out_en, busy, sw_done, sel_err, lock_err});
      end
      rst_n = 1'b1;
      en_seen = 0; loads = 0; busy_seen = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (clk_out_en) en_seen = 1;
         if (div_load) loads++;
         if (busy) busy_seen++;
      end
      checks++; if (en_seen !== 1) begin failures++;
         $display("FAIL reset_release_en: got %0d expected 1", en_seen); end
      checks++; if (loads !== 0) begin failures++;
         $display("FAIL reset_release_load: got %0d expected 0", loads); end
      checks++; if (busy_seen !== 0) begin failures++;
         $display("FAIL reset_release_busy: got %0d expected 0", busy_seen); end
      checks++; if (div_sel !== 3'd0) begin failures++;
         $display("FAIL reset_release_div_sel: got %0d expected 0", div_sel); end
   endtask

   task automatic test_gating();
      logic en, gate;
      for (int i = 0; i < 8; i++) begin
         en   = 1'($urandom_range(0, 1));
         gate = 1'($urandom_range(0, 1));
         ctl_reg      = $urandom();
         ctl_reg[2:0] = m_active;
         ctl_reg[3]   = en;
         ctl_reg[4]   = gate;
         @(negedge clk);
         checks++; if ({clk_out_en, busy} !== {en & ~gate, 1'b0}) begin failures++;
            $display("FAIL gating en=%0d gate=%0d: got %b expected %b", en, gate,
                     {clk_out_en, busy}, {en & ~gate, 1'b0});
         end
      end
      ctl_reg = {27'd0, 2'b01, m_active};
      @(negedge clk);
   endtask

   task automatic test_switch();
      run_txn(3'd3, 3, 3);
   endtask

   task automatic test_sel_err();
      run_txn(3'd5, 3, 3);
      run_txn(3'd7, 3, 3);
   endtask

   task automatic test_lock_timeout();
      run_txn(3'd4, NEVER, 3);
      run_txn(3'd4, 3, 3);
      run_txn(3'd2, 3, 3);
      run_txn(3'd1, NEVER, NEVER);
      run_txn(3'd0, 2, 3);
   endtask

   task automatic test_back_to_back();
      int busy_cnt, n_loads, sw_cnt, sw_first, sw_last, en_early;
      int exp_first, exp_last;
      logic [2:0] load_sel [2];
      exp_first = DRAIN + 1 + 3 + SETTLE + 1;
      exp_last  = 2 * exp_first;
      busy_cnt = 0; n_loads = 0; sw_cnt = 0; sw_first = 0; sw_last = 0; en_early = 0;
      load_sel[0] = 3'd0;
      load_sel[1] = 3'd0;
      lock_plan.delete();
      lock_plan.push_back(3);
      lock_plan.push_back(3);
      ctl_reg = 32'h09;
      for (int i = 1; i <= exp_last + 3; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (div_load) begin
            if (n_loads < 2) load_sel[n_loads] = div_sel;
            n_loads++;
         end
         if (sw_done) begin
            sw_cnt++;
            if (sw_first == 0) sw_first = i;
            sw_last = i;
         end
         if (clk_out_en && (i <= exp_last)) en_early++;
         if (i == DRAIN + 3) ctl_reg = 32'h0A;
      end
      m_active = 3'd2;
      m_divsel = 3'd2;
      checks++; if (n_loads !== 2) begin failures++;
         $display("FAIL b2b_loads: got %0d expected 2", n_loads); end
      checks++; if ({load_sel[0], load_sel[1]} !== {3'd1, 3'd2}) begin failures++;
         $display("FAIL b2b_load_sels: got %0d,%0d expected 1,2", load_sel[0], load_sel[1]); end
      checks++; if (sw_cnt !== 2) begin failures++;
         $display("FAIL b2b_sw_done_count: got %0d expected 2", sw_cnt); end
      checks++; if ({sw_first, sw_last} !== {exp_first, exp_last}) begin failures++;
         $display("FAIL b2b_sw_done_times: got %0d,%0d expected %0d,%0d",
                  sw_first, sw_last, exp_first, exp_last); end
      checks++; if (busy_cnt !== exp_last - 2) begin failures++;
         $display("FAIL b2b_busy_cycles: got %0d expected %0d", busy_cnt, exp_last - 2); end
      checks++; if (en_early !== 0) begin failures++;
         $display("FAIL b2b_early_ungate: got %0d expected 0", en_early); end
      checks++; if ({clk_out_en, div_sel} !== {1'b1, 3'd2}) begin failures++;
         $display("FAIL b2b_final: got en=%0d div_sel=%0d expected en=1 div_sel=2", clk_out_en, div_sel); end
   endtask

   task automatic test_reset_mid();
      lock_plan.delete();
      lock_plan.push_back(3);
      ctl_reg = 32'h0B;
      repeat (DRAIN + 1 + 3 + 3) @(negedge clk);
      checks++; if (busy !== 1'b1) begin failures++;
         $display("FAIL mid_busy_before_reset: got %0d expected 1", busy); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({div_sel, div_load, clk_out_en, busy, sw_done, sel_err, lock_err} !== 9'd0) begin
         failures++;
         $display("FAIL mid_reset_outputs: got %b expected 0",
                  {div_sel, div_load, clk_out_en, busy, sw_done, sel_err, lock_err});
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      run_txn(3'd3, 3, 3);
   endtask

   task automatic test_random();
      logic [2:0] s;
      int d1, d2;
      for (int i = 0; i < 16; i++) begin
         s  = 3'($urandom_range(0, 7));
         d1 = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(1, 8));
         d2 = ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(1, 8));
         run_txn(s, d1, d2);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      ctl_reg = 32'h0;
      model_reset();
      test_reset();
      test_gating();
      test_switch();
      test_sel_err();
      test_lock_timeout();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/db_unit_clk_switch_ctl.md
Name: db_unit_clk_switch_ctl

Overview:
Sequences run-time frequency changes of db_unit_clk inside the CRCU. It watches the DB unit clock-control register's select/enable/gate fields and drives the divider-select and load handshake to the db_unit clock divider. It also drives the output clock-enable gate. Output is gated off before any divider change and re-enabled only after the divider reports lock and a settle interval, so no runt pulses reach the DB unit.

Parameters:
DRAIN_CYC, 4, CRCU_CLK cycles output stays gated before divider reload (>=1)
SETTLE_CYC, 8, CRCU_CLK cycles after lock before ungating (>=1)
LOCK_TIMEOUT, 256, max CRCU_CLK cycles waiting for div_locked after div_load (>=2)

Ports:
CRCU_CLK  input  1  CRCU reference clock; all logic on rising edge
CRCU_RST_N  input  1  async active-low reset
db_unit_clock_ctl_reg  input  32  [2:0] freq select (0=100M,1=125M,2=180M,3=300M,4=600M; 5-7 invalid), [3] clk enable, [4] clk gating; other bits ignored; quasi-static, CRCU_CLK domain
div_locked  input  1  divider reports output stable at div_sel; may drop after div_load
div_sel  output  3  select applied to divider
div_load  output  1  1-cycle pulse: divider samples div_sel
clk_out_en  output  1  gate enable for db_unit_clk
busy  output  1  high in every state except IDLE
sw_done  output  1  1-cycle pulse on successful switch completion
sel_err  output  1  1-cycle pulse when reg select 5-7 is seen in IDLE
lock_err  output  1  sticky; set on lock timeout, cleared on next successful switch

Behaviour:
- Reset (async assert, sync deassert assumed upstream): state=IDLE, div_sel=0, active_sel=0, failed_sel=none, counters 0, all 1-bit outputs 0.
- clk_out_en = reg[3] & ~reg[4] & (state==IDLE), registered (1-cycle latency from reg change); forced 0 in all other states.
- States: IDLE, DRAIN, LOAD, WAIT_LOCK, SETTLE.
- IDLE: if reg[2:0]>4 -> pulse sel_err, stay. Pulse repeats each cycle while invalid. Else if reg[2:0]!=active_sel and reg[2:0]!=failed_sel -> tgt<=reg[2:0], cnt<=0, go DRAIN.
- DRAIN: count DRAIN_CYC cycles, then go LOAD.
- LOAD: div_sel<=tgt, div_load=1 for exactly this cycle, cnt<=0, go WAIT_LOCK.
- WAIT_LOCK: ignore div_locked in the first cycle after div_load. Afterwards, div_locked=1 -> cnt<=0, go SETTLE. If cnt reaches LOCK_TIMEOUT first: lock_err<=1, failed_sel<=tgt, tgt<=active_sel, go LOAD (reverts divider to the previous select; this revert is never itself timed out twice: a second timeout leaves div_sel as-is and goes SETTLE).
- SETTLE: count SETTLE_CYC cycles. Then:
  - If reloading a new target: active_sel<=tgt, lock_err<=0, failed_sel<=none, pulse sw_done.
  - If in revert: no sw_done.
  - Go IDLE. If reg select already differs from active_sel, IDLE re-launches the next cycle, so clk_out_en stays 0 (IDLE gating only enables after the registered compare shows no pending switch).
- failed_sel is cleared when reg[2:0] changes to a value different from failed_sel, so the same failed request is not retried endlessly.
- Reg select changes during busy are not sampled until IDLE; only the latest value is acted on, with no queuing.
- Enable/gate bits changing mid-sequence do not abort it; they only affect clk_out_en once in IDLE.
- Reset mid-sequence: immediate return to reset values; divider reverts via div_sel=0 with no div_load (divider also reset).
- Counters are $clog2(max param)+1 bits wide, saturating, no wrap.

Test Plan:
- Reset, reg=0x08 -> after release clk_out_en=1 within 2 cycles, div_sel=0, busy=0, no div_load.
- reg 0x08->0x0B, div_locked returns 3 cycles after div_load -> clk_out_en low for DRAIN 4 cycles; div_load single pulse with div_sel=3; sw_done one cycle after 8 SETTLE cycles; clk_out_en=1 next cycle.
- reg 0x0D (sel=5) in IDLE -> sel_err pulses every cycle, div_load never asserted, clk_out_en stays 1, div_sel unchanged.
- reg sel=4, div_locked held 0 -> lock_err=1 at cycle 256 after div_load; second div_load with div_sel reverted to previous; no sw_done; no retry while reg stays 4; writing sel=2 with good lock clears lock_err and pulses sw_done.
- reg 0x09 then 0x0A written during WAIT_LOCK -> first switch completes (div_sel=1), clk_out_en stays 0, second sequence starts immediately, ends div_sel=2 with two sw_done pulses total.
- Assert CRCU_RST_N=0 mid-SETTLE -> all outputs 0, div_sel=0 same cycle (async); after release with reg sel=3 a fresh full sequence runs.
